rob_wide_commit: RTL and testbench
==================================

// Module: rob_wide_commit
// PURPOSE
//  Parametrised reorder buffer: circular queue of DEPTH in-flight instructions.
//  Snoops CDB_N result buses; retires up to 2 entries per cycle in program order.
//  Sits between decoder (issue), ALU/LSB (results) and regfile/LSB/fetcher (commit).
//  Adds over the single-commit ROB: configurable depth, N result buses, dual commit,
//  same-cycle CDB forwarding on operand lookup.
// PARAMETERS
//  DEPTH   16  entries; tag = slot index + 1; tag 0 = NULL_TAG
//  TAG_W   5   tag width; must satisfy 2**TAG_W > DEPTH
//  XLEN    32  data/pc width
//  CDB_N   2   result buses snooped per cycle
// PORTS
//  clk            in   1              clock
//  rst            in   1              synchronous, active-high reset
//  iss_valid      in   1              decoder issues one instruction
//  iss_ready      out  1              count < DEPTH (combinational)
//  iss_tag        out  TAG_W          tag assigned to this cycle's issue
//  iss_kind       in   2              0=ALU/LOAD 1=STORE 2=BRANCH 3=JALR
//  iss_rd         in   5              destination register
//  iss_pc         in   XLEN           instruction pc
//  iss_pred_pc    in   XLEN           predicted next pc
//  cdb_valid      in   CDB_N          per-bus result valid
//  cdb_tag        in   CDB_N*TAG_W    per-bus destination tag
//  cdb_data       in   CDB_N*XLEN     per-bus result
//  cdb_npc        in   CDB_N*XLEN     per-bus resolved next pc (branch/jalr)
//  q_tag          in   2*TAG_W        two operand lookup tags
//  q_ready        out  2              operand value available
//  q_data         out  2*XLEN         operand value
//  cm_valid       out  2              commit lane valid (registered pulse)
//  cm_tag         out  2*TAG_W        committed tag per lane
//  cm_rd          out  2*5            dest register; 0 for STORE/BRANCH
//  cm_data        out  2*XLEN         committed value
//  cm_store       out  2              lane commits a STORE (LSB release)
//  rollback       out  1              mispredict flush pulse
//  rollback_pc    out  XLEN           redirect target
// BEHAVIOUR
//  Reset: head=0, tail=0, count=0, all entry valid/ready=0.
//    All outputs registered; cm_valid, cm_store, rollback = 0.
//    cm_* data fields and rollback_pc = 0.
//  Issue: accepted when iss_valid && iss_ready.
//    Writes slot tail with ready=0; tail wraps DEPTH-1 -> 0.
//    iss_tag = tail+1 whenever iss_ready, else NULL_TAG.
//    iss_ready uses pre-edge count only; no same-cycle commit credit.
//    Issue while full is ignored.
//  CDB: for each bus i, if valid and tag names an occupied slot:
//    set ready=1 and store data and npc.
//    Tag 0 or unoccupied tag is ignored.
//    Two buses with the same tag: lowest index wins.
//  Lookup (combinational) for q_tag:
//    a. occupied and ready -> stored data;
//    b. else a matching cdb_valid bus this cycle -> its data (forward);
//    c. else q_ready=0.
//    NULL or unoccupied tag -> q_ready=0, q_data=0.
//  Commit lane0, head entry H0, when count>=1 and (H0.ready or H0.kind==STORE).
//    STORE commits at head without waiting for ready.
//  Commit lane1, entry H0+1 (wrapping), when all of:
//    lane0 commits; count>=2; H1 eligible;
//    H0 not BRANCH/JALR; not both STORE.
//  Readiness is sampled pre-edge: a CDB write to head this cycle commits next cycle.
//  Mispredict: committing BRANCH/JALR with npc != pred_pc:
//    next edge drives cm_valid lane0 plus rollback=1, rollback_pc=npc;
//    same edge clears queue to reset state; that cycle's issue is discarded.
//  count' = count + issue - commits (0..DEPTH, width TAG_W+1).
//  rst mid-operation overrides issue, CDB and commit in that cycle.
// TESTING
//  1. DEPTH=4: issue 4 -> iss_ready=0; 5th issue ignored; iss_tag=0 while full.
//  2. Issue tags 1,2; CDB both buses same cycle with data 0x11, 0x22.
//     -> next-next cycle cm_valid=2'b11, cm_data={0x22,0x11}.
//  3. Branch tag 1 pred 0x100, CDB npc 0x200, tag 2 ready.
//     -> lane0 only, rollback=1, rollback_pc=0x200.
//     -> following cycle count=0, iss_tag=1.
//  4. Two STOREs at head, not ready -> cm_store=01 then 01 on consecutive cycles.
//  5. q_tag=3 while cdb bus1 broadcasts tag3 data 0xABCD.
//     -> q_ready=1, q_data=0xABCD same cycle.
//  6. Fill, commit and issue across wrap (DEPTH=4, 10 instructions).
//     -> tags cycle 1..4 in order; rst mid-stream -> count=0, outputs 0 next cycle.

Source files
------------

// File: rtl/rob_wide_commit.sv
// rob_wide_commit
//   Reorder buffer holding DEPTH in-flight instructions as a circular queue.
//   Instructions enter in program order from the decoder. Results arrive from
//   CDB_N result buses. Up to two entries retire per cycle, in program order,
//   toward the register file, the LSB and the fetcher. A mispredicted
//   BRANCH/JALR at the head flushes the whole queue and redirects fetch.
//   Tags are slot index + 1, so tag 0 can serve as the "no producer" tag.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   iss_valid_i       decoder presents one instruction this cycle
//   iss_ready_o       queue has a free slot (combinational, pre-edge count)
//   iss_tag_o         tag the presented instruction receives (0 when full)
//   iss_kind_i        0=ALU/LOAD 1=STORE 2=BRANCH 3=JALR
//   iss_rd_i          destination register
//   iss_pc_i          instruction pc
//   iss_pred_pc_i     predicted next pc
//   cdb_valid_i       per-bus result valid
//   cdb_tag_i         per-bus producer tag
//   cdb_data_i        per-bus result value
//   cdb_npc_i         per-bus resolved next pc
//   q_tag_i           two operand lookup tags
//   q_ready_o         operand value is available (stored or forwarded)
//   q_data_o          operand value
//   cm_valid_o        commit lane valid, registered pulse
//   cm_tag_o          committed tag per lane
//   cm_rd_o           committed destination, 0 for STORE/BRANCH
//   cm_data_o         committed value per lane
//   cm_store_o        lane retires a STORE (LSB may release it)
//   rollback_o        mispredict flush pulse
//   rollback_pc_o     redirect target for the flush
module rob_wide_commit #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 5,
  parameter int XLEN  = 32,
  parameter int CDB_N = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid_i,
  output logic                   iss_ready_o,
  output logic [TAG_W-1:0]       iss_tag_o,
  input  logic [1:0]             iss_kind_i,
  input  logic [4:0]             iss_rd_i,
  input  logic [XLEN-1:0]        iss_pc_i,
  input  logic [XLEN-1:0]        iss_pred_pc_i,
  input  logic [CDB_N-1:0]       cdb_valid_i,
  input  logic [CDB_N*TAG_W-1:0] cdb_tag_i,
  input  logic [CDB_N*XLEN-1:0]  cdb_data_i,
  input  logic [CDB_N*XLEN-1:0]  cdb_npc_i,
  input  logic [2*TAG_W-1:0]     q_tag_i,
  output logic [1:0]             q_ready_o,
  output logic [2*XLEN-1:0]      q_data_o,
  output logic [1:0]             cm_valid_o,
  output logic [2*TAG_W-1:0]     cm_tag_o,
  output logic [9:0]             cm_rd_o,
  output logic [2*XLEN-1:0]      cm_data_o,
  output logic [1:0]             cm_store_o,
  output logic                   rollback_o,
  output logic [XLEN-1:0]        rollback_pc_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = TAG_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [TAG_W-1:0] MAX_TAG  = TAG_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] KIND_STORE  = 2'd1;
  localparam logic [1:0] KIND_BRANCH = 2'd2;
  localparam logic [1:0] KIND_JALR   = 2'd3;

  // Entry storage
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] ready_q;
  logic [1:0]       kind_q   [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [XLEN-1:0]  data_q   [DEPTH];
  logic [XLEN-1:0]  npc_q    [DEPTH];
  logic [XLEN-1:0]  predPc_q [DEPTH];

  // Queue pointers
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Registered commit / rollback outputs
  logic [1:0]         cmValid_q, cmValid_d;
  logic [2*TAG_W-1:0] cmTag_q, cmTag_d;
  logic [9:0]         cmRd_q, cmRd_d;
  logic [2*XLEN-1:0]  cmData_q, cmData_d;
  logic [1:0]         cmStore_q, cmStore_d;
  logic               rollback_q, rollback_d;
  logic [XLEN-1:0]    rollbackPc_q, rollbackPc_d;

  // Decoded CDB and lookup information
  logic [TAG_W-1:0] cdbTag  [CDB_N];
  logic [IDX_W-1:0] cdbSlot [CDB_N];
  logic [CDB_N-1:0] cdbHit;
  logic [TAG_W-1:0] lkTag   [2];
  logic [IDX_W-1:0] lkSlot  [2];

  // Commit decision
  logic [IDX_W-1:0] h0, h1;
  logic             store0, store1, ctrl0;
  logic             commit0, commit1, mispredict;
  logic             issueFire;

  // The ROB never needs the instruction pc: redirects come from the resolved
  // npc on the CDB. The port stays so the decoder interface is unchanged.
  logic pcUnused;
  assign pcUnused = ^iss_pc_i;

  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] tagToIdx(input logic [TAG_W-1:0] t);
    return IDX_W'(t - TAG_W'(1));
  endfunction

  function automatic logic [TAG_W-1:0] idxToTag(input logic [IDX_W-1:0] i);
    return TAG_W'(i) + TAG_W'(1);
  endfunction

  function automatic logic tagInRange(input logic [TAG_W-1:0] t);
    return (t != '0) && (t <= MAX_TAG);
  endfunction

  // STORE and BRANCH do not write the register file, so their rd is hidden.
  function automatic logic [4:0] visibleRd(input logic [1:0] k, input logic [4:0] rd);
    return ((k == KIND_STORE) || (k == KIND_BRANCH)) ? 5'd0 : rd;
  endfunction

  // No same-cycle commit credit: a full queue refuses issue even if the
  // head retires on this very edge.
  assign iss_ready_o = (count_q < FULL_CNT);
  assign iss_tag_o   = iss_ready_o ? idxToTag(tail_q) : '0;
  assign issueFire   = iss_valid_i && iss_ready_o;

  // A bus only counts when its tag names a slot that is occupied right now.
  always_comb begin
    for (int i = 0; i < CDB_N; i++) begin
      cdbTag[i]  = cdb_tag_i[i*TAG_W +: TAG_W];
      cdbSlot[i] = tagToIdx(cdbTag[i]);
      cdbHit[i]  = cdb_valid_i[i] && tagInRange(cdbTag[i]) && valid_q[cdbSlot[i]];
    end
  end

  // Operand lookup: stored value first, otherwise forward from this cycle's
  // CDB. Buses are scanned high to low so the lowest matching index wins.
  always_comb begin
    q_ready_o = '0;
    q_data_o  = '0;
    for (int l = 0; l < 2; l++) begin
      lkTag[l]  = q_tag_i[l*TAG_W +: TAG_W];
      lkSlot[l] = tagToIdx(lkTag[l]);
      if (tagInRange(lkTag[l]) && valid_q[lkSlot[l]]) begin
        if (ready_q[lkSlot[l]]) begin
          q_ready_o[l]               = 1'b1;
          q_data_o[l*XLEN +: XLEN]   = data_q[lkSlot[l]];
        end else begin
          for (int i = CDB_N - 1; i >= 0; i--) begin
            if (cdb_valid_i[i] && (cdbTag[i] == lkTag[l])) begin
              q_ready_o[l]             = 1'b1;
              q_data_o[l*XLEN +: XLEN] = cdb_data_i[i*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

  // Commit selection on pre-edge state. Lane1 is withheld behind a control
  // transfer (it may flush) and when both heads are STOREs, since the LSB
  // releases at most one store per cycle.
  always_comb begin
    h0      = head_q;
    h1      = nextIdx(head_q);
    store0  = (kind_q[h0] == KIND_STORE);
    store1  = (kind_q[h1] == KIND_STORE);
    ctrl0   = (kind_q[h0] == KIND_BRANCH) || (kind_q[h0] == KIND_JALR);
    commit0 = (count_q != '0) && valid_q[h0] && (ready_q[h0] || store0);
    commit1 = commit0 && (count_q >= CNT_W'(2)) && valid_q[h1] &&
              (ready_q[h1] || store1) && !ctrl0 && !(store0 && store1);
    mispredict = commit0 && ctrl0 && (npc_q[h0] != predPc_q[h0]);
  end

  // Next pointers and next registered outputs. A mispredict empties the
  // queue and drops this cycle's issue.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    cmValid_d    = {commit1, commit0};
    cmTag_d      = '0;
    cmRd_d       = '0;
    cmData_d     = '0;
    cmStore_d    = {commit1 && store1, commit0 && store0};
    rollback_d   = mispredict;
    rollbackPc_d = mispredict ? npc_q[h0] : '0;

    if (commit0) begin
      cmTag_d[0 +: TAG_W]  = idxToTag(h0);
      cmRd_d[4:0]          = visibleRd(kind_q[h0], rd_q[h0]);
      cmData_d[0 +: XLEN]  = data_q[h0];
    end
    if (commit1) begin
      cmTag_d[TAG_W +: TAG_W] = idxToTag(h1);
      cmRd_d[9:5]             = visibleRd(kind_q[h1], rd_q[h1]);
      cmData_d[XLEN +: XLEN]  = data_q[h1];
    end

    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit1) begin
        head_d = nextIdx(h1);
      end else if (commit0) begin
        head_d = h1;
      end
      if (issueFire) begin
        tail_d = nextIdx(tail_q);
      end
      count_d = count_q + CNT_W'(issueFire) - CNT_W'(commit0) - CNT_W'(commit1);
    end
  end

  // State update. An issue slot is never occupied, and CDB hits only touch
  // occupied slots, so issue and CDB writes never collide on one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      ready_q      <= '0;
      cmValid_q    <= '0;
      cmTag_q      <= '0;
      cmRd_q       <= '0;
      cmData_q     <= '0;
      cmStore_q    <= '0;
      rollback_q   <= 1'b0;
      rollbackPc_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      cmValid_q    <= cmValid_d;
      cmTag_q      <= cmTag_d;
      cmRd_q       <= cmRd_d;
      cmData_q     <= cmData_d;
      cmStore_q    <= cmStore_d;
      rollback_q   <= rollback_d;
      rollbackPc_q <= rollbackPc_d;
      if (mispredict) begin
        valid_q <= '0;
        ready_q <= '0;
      end else begin
        for (int i = CDB_N - 1; i >= 0; i--) begin
          if (cdbHit[i]) begin
            ready_q[cdbSlot[i]] <= 1'b1;
            data_q[cdbSlot[i]]  <= cdb_data_i[i*XLEN +: XLEN];
            npc_q[cdbSlot[i]]   <= cdb_npc_i[i*XLEN +: XLEN];
          end
        end
        if (commit0) begin
          valid_q[h0] <= 1'b0;
        end
        if (commit1) begin
          valid_q[h1] <= 1'b0;
        end
        if (issueFire) begin
          valid_q[tail_q]  <= 1'b1;
          ready_q[tail_q]  <= 1'b0;
          kind_q[tail_q]   <= iss_kind_i;
          rd_q[tail_q]     <= iss_rd_i;
          predPc_q[tail_q] <= iss_pred_pc_i;
          data_q[tail_q]   <= '0;
          npc_q[tail_q]    <= '0;
        end
      end
    end
  end

  assign cm_valid_o    = cmValid_q;
  assign cm_tag_o      = cmTag_q;
  assign cm_rd_o       = cmRd_q;
  assign cm_data_o     = cmData_q;
  assign cm_store_o    = cmStore_q;
  assign rollback_o    = rollback_q;
  assign rollback_pc_o = rollbackPc_q;

endmodule

// File: tb/tb_rob_wide_commit.sv
// tb_rob_wide_commit
//   Directed bench for rob_wide_commit built with DEPTH=4, TAG_W=3.
//   A vector table walks through issue, CDB capture, forwarding, full queue
//   and dual commit. Hand-written sequences then cover mispredict flush,
//   JALR lane blocking, back-to-back stores, pointer wrap and reset mid-stream.
module tb_rob_wide_commit;

  localparam int DEPTH = 4;
  localparam int TAG_W = 3;
  localparam int XLEN  = 32;
  localparam int CDB_N = 2;
  localparam int NVEC  = 13;

  logic                   clk;
  logic                   rst;
  logic                   iss_valid;
  logic                   iss_ready;
  logic [TAG_W-1:0]       iss_tag;
  logic [1:0]             iss_kind;
  logic [4:0]             iss_rd;
  logic [XLEN-1:0]        iss_pc;
  logic [XLEN-1:0]        iss_pred_pc;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*XLEN-1:0]  cdb_data;
  logic [CDB_N*XLEN-1:0]  cdb_npc;
  logic [2*TAG_W-1:0]     q_tag;
  logic [1:0]             q_ready;
  logic [2*XLEN-1:0]      q_data;
  logic [1:0]             cm_valid;
  logic [2*TAG_W-1:0]     cm_tag;
  logic [9:0]             cm_rd;
  logic [2*XLEN-1:0]      cm_data;
  logic [1:0]             cm_store;
  logic                   rollback;
  logic [XLEN-1:0]        rollback_pc;

  int checks;
  int errors;

  typedef struct {
    logic        issValid;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [1:0]  cdbValid;
    logic [2:0]  cdbTag0;
    logic [2:0]  cdbTag1;
    logic [31:0] cdbData0;
    logic [31:0] cdbData1;
    logic [2:0]  qTag;
    logic        expIssReady;
    logic [2:0]  expIssTag;
    logic        expQReady;
    logic [31:0] expQData;
    logic [1:0]  expCmValid;
    logic [2:0]  expCmTag0;
    logic [31:0] expCmData0;
    logic [31:0] expCmData1;
  } vec_t;

  vec_t vecs [NVEC];

  rob_wide_commit #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W),
    .XLEN (XLEN),
    .CDB_N(CDB_N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .iss_valid_i  (iss_valid),
    .iss_ready_o  (iss_ready),
    .iss_tag_o    (iss_tag),
    .iss_kind_i   (iss_kind),
    .iss_rd_i     (iss_rd),
    .iss_pc_i     (iss_pc),
    .iss_pred_pc_i(iss_pred_pc),
    .cdb_valid_i  (cdb_valid),
    .cdb_tag_i    (cdb_tag),
    .cdb_data_i   (cdb_data),
    .cdb_npc_i    (cdb_npc),
    .q_tag_i      (q_tag),
    .q_ready_o    (q_ready),
    .q_data_o     (q_data),
    .cm_valid_o   (cm_valid),
    .cm_tag_o     (cm_tag),
    .cm_rd_o      (cm_rd),
    .cm_data_o    (cm_data),
    .cm_store_o   (cm_store),
    .rollback_o   (rollback),
    .rollback_pc_o(rollback_pc)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    iss_valid   = 1'b0;
    iss_kind    = 2'd0;
    iss_rd      = 5'd0;
    iss_pc      = '0;
    iss_pred_pc = '0;
    cdb_valid   = '0;
    cdb_tag     = '0;
    cdb_data    = '0;
    cdb_npc     = '0;
    q_tag       = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    iss_valid   = v.issValid;
    iss_kind    = v.kind;
    iss_rd      = v.rd;
    iss_pc      = '0;
    iss_pred_pc = '0;
    cdb_valid   = v.cdbValid;
    cdb_tag     = {v.cdbTag1, v.cdbTag0};
    cdb_data    = {v.cdbData1, v.cdbData0};
    cdb_npc     = '0;
    q_tag       = {v.qTag, v.qTag};
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic issueOne(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pred);
    iss_valid   = 1'b1;
    iss_kind    = kind;
    iss_rd      = rd;
    iss_pred_pc = pred;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idleInputs();

    // issV kind rd | cdbV tag0 tag1 data0 data1 | qTag | rdy issTag qRdy qData | cmV cmTag0 cmData0 cmData1
    vecs[0]  = '{1'b1, 2'd0, 5'd1, 2'b00, 3'd0, 3'd0, 32'h0,  32'h0,    3'd0, 1'b1, 3'd1, 1'b0, 32'h0,    2'b00, 3'd0, 32'h0,    32'h0};
    vecs[1]  = '{1'b1, 2'd0, 5'd2, 2'b00, 3'd0, 3'd0, 32'h0,  32'h0,    3'd1, 1'b1, 3'd2, 1'b0, 32'h0,    2'b00, 3'd0, 32'h0,    32'h0};
    vecs[2]  = '{1'b1, 2'd0, 5'd3, 2'b11, 3'd1, 3'd2, 32'h11, 32'h22,   3'd2, 1'b1, 3'd3, 1'b1, 32'h22,   2'b00, 3'd0, 32'h0,    32'h0};
    vecs[3]  = '{1'b1, 2'd0, 5'd4, 2'b10, 3'd0, 3'd3, 32'h0,  32'hABCD, 3'd3, 1'b1, 3'd4, 1'b1, 32'hABCD, 2'b11, 3'd1, 32'h11,   32'h22};
    vecs[4]  = '{1'b0, 2'd0, 5'd0, 2'b00, 3'd0, 3'd0, 32'h0,  32'h0,    3'd3, 1'b1, 3'd1, 1'b1, 32'hABCD, 2'b01, 3'd3, 32'hABCD, 32'h0};
    vecs[5]  = '{1'b1, 2'd0, 5'd5, 2'b00, 3'd0, 3'd0, 32'h0,  32'h0,    3'd0, 1'b1, 3'd1, 1'b0, 32'h0,    2'b00, 3'd0, 32'h0,    32'h0};
    vecs[6]  = '{1'b1, 2'd0, 5'd6, 2'b00, 3'd0, 3'd0, 32'h0,  32'h0,    3'd0, 1'b1, 3'd2, 1'b0, 32'h0,    2'b00, 3'd0, 32'h0,    32'h0};
    vecs[7]  = '{1'b1, 2'd0, 5'd7, 2'b00, 3'd0, 3'd0, 32'h0,  32'h0,    3'd0, 1'b1, 3'd3, 1'b0, 32'h0,    2'b00, 3'd0, 32'h0,    32'h0};
    vecs[8]  = '{1'b1, 2'd0, 5'd8, 2'b00, 3'd0, 3'd0, 32'h0,  32'h0,    3'd0, 1'b0, 3'd0, 1'b0, 32'h0,    2'b00, 3'd0, 32'h0,    32'h0};
    vecs[9]  = '{1'b1, 2'd0, 5'd9, 2'b11, 3'd4, 3'd4, 32'h44, 32'h55,   3'd4, 1'b0, 3'd0, 1'b1, 32'h44,   2'b00, 3'd0, 32'h0,    32'h0};
    vecs[10] = '{1'b0, 2'd0, 5'd0, 2'b00, 3'd0, 3'd0, 32'h0,  32'h0,    3'd4, 1'b0, 3'd0, 1'b1, 32'h44,   2'b01, 3'd4, 32'h44,   32'h0};
    vecs[11] = '{1'b0, 2'd0, 5'd0, 2'b01, 3'd4, 3'd0, 32'h99, 32'h0,    3'd4, 1'b1, 3'd4, 1'b0, 32'h0,    2'b00, 3'd0, 32'h0,    32'h0};
    vecs[12] = '{1'b0, 2'd0, 5'd0, 2'b10, 3'd0, 3'd1, 32'h0,  32'h12,   3'd1, 1'b1, 3'd4, 1'b1, 32'h12,   2'b00, 3'd0, 32'h0,    32'h0};

    // Reset state
    doReset();
    checkOutput("reset cm_valid", 64'(cm_valid), 64'd0);
    checkOutput("reset cm_store", 64'(cm_store), 64'd0);
    checkOutput("reset cm_data", cm_data, 64'd0);
    checkOutput("reset rollback", 64'(rollback), 64'd0);
    checkOutput("reset rollback_pc", 64'(rollback_pc), 64'd0);
    checkOutput("reset iss_ready", 64'(iss_ready), 64'd1);
    checkOutput("reset iss_tag", 64'(iss_tag), 64'd1);
    checkOutput("reset q_ready", 64'(q_ready), 64'd0);

    // Table: combinational outputs checked before the edge, commit outputs after
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d iss_ready", i), 64'(iss_ready), 64'(vecs[i].expIssReady));
      checkOutput($sformatf("v%0d iss_tag", i), 64'(iss_tag), 64'(vecs[i].expIssTag));
      checkOutput($sformatf("v%0d q_ready", i), 64'(q_ready), 64'({vecs[i].expQReady, vecs[i].expQReady}));
      checkOutput($sformatf("v%0d q_data", i), q_data, {vecs[i].expQData, vecs[i].expQData});
      step();
      checkOutput($sformatf("v%0d cm_valid", i), 64'(cm_valid), 64'(vecs[i].expCmValid));
      checkOutput($sformatf("v%0d cm_tag0", i), 64'(cm_tag[2:0]), 64'(vecs[i].expCmTag0));
      checkOutput($sformatf("v%0d cm_data", i), cm_data, {vecs[i].expCmData1, vecs[i].expCmData0});
      checkOutput($sformatf("v%0d cm_store", i), 64'(cm_store), 64'd0);
    end

    // Branch mispredict: lane0 only, flush, dropped issue
    doReset();
    issueOne(2'd2, 5'd3, 32'h100);
    #1 checkOutput("br iss_tag1", 64'(iss_tag), 64'd1);
    step();
    issueOne(2'd0, 5'd7, 32'h0);
    #1 checkOutput("br iss_tag2", 64'(iss_tag), 64'd2);
    step();
    idleInputs();
    cdb_valid = 2'b11;
    cdb_tag   = {3'd2, 3'd1};
    cdb_data  = {32'h77, 32'h0};
    cdb_npc   = {32'h0, 32'h200};
    step();
    checkOutput("br cm_valid wait", 64'(cm_valid), 64'd0);
    idleInputs();
    issueOne(2'd0, 5'd9, 32'h0);
    q_tag = {3'd2, 3'd1};
    #1;
    checkOutput("br q_ready", 64'(q_ready), 64'd3);
    checkOutput("br q_data", q_data, {32'h77, 32'h0});
    checkOutput("br iss_tag3", 64'(iss_tag), 64'd3);
    step();
    checkOutput("br cm_valid", 64'(cm_valid), 64'd1);
    checkOutput("br cm_tag", 64'(cm_tag[2:0]), 64'd1);
    checkOutput("br cm_rd", 64'(cm_rd[4:0]), 64'd0);
    checkOutput("br rollback", 64'(rollback), 64'd1);
    checkOutput("br rollback_pc", 64'(rollback_pc), 64'h200);
    iss_valid = 1'b0;
    #1;
    checkOutput("br flushed iss_tag", 64'(iss_tag), 64'd1);
    checkOutput("br flushed iss_ready", 64'(iss_ready), 64'd1);
    checkOutput("br flushed q_ready", 64'(q_ready), 64'd0);
    step();
    checkOutput("br after cm_valid", 64'(cm_valid), 64'd0);
    checkOutput("br after rollback", 64'(rollback), 64'd0);

    // Correctly predicted JALR keeps lane1 idle behind it
    issueOne(2'd3, 5'd1, 32'h40);
    step();
    issueOne(2'd0, 5'd2, 32'h0);
    step();
    idleInputs();
    cdb_valid = 2'b11;
    cdb_tag   = {3'd1, 3'd2};
    cdb_data  = {32'h8, 32'h9};
    cdb_npc   = {32'h40, 32'h0};
    step();
    checkOutput("jalr wait cm_valid", 64'(cm_valid), 64'd0);
    idleInputs();
    step();
    checkOutput("jalr cm_valid", 64'(cm_valid), 64'd1);
    checkOutput("jalr cm_rd", 64'(cm_rd[4:0]), 64'd1);
    checkOutput("jalr cm_data", 64'(cm_data[31:0]), 64'h8);
    checkOutput("jalr rollback", 64'(rollback), 64'd0);
    step();
    checkOutput("jalr next cm_valid", 64'(cm_valid), 64'd1);
    checkOutput("jalr next cm_tag", 64'(cm_tag[2:0]), 64'd2);
    checkOutput("jalr next cm_rd", 64'(cm_rd[4:0]), 64'd2);
    checkOutput("jalr next cm_data", 64'(cm_data[31:0]), 64'h9);

    // Stores: ALU+STORE pair, then two stores at head retire one per cycle
    doReset();
    issueOne(2'd0, 5'd1, 32'h0);
    step();
    issueOne(2'd1, 5'd5, 32'h0);
    step();
    issueOne(2'd1, 5'd6, 32'h0);
    step();
    issueOne(2'd1, 5'd7, 32'h0);
    cdb_valid = 2'b01;
    cdb_tag   = {3'd0, 3'd1};
    cdb_data  = {32'h0, 32'h5};
    step();
    checkOutput("st blocked cm_valid", 64'(cm_valid), 64'd0);
    idleInputs();
    step();
    checkOutput("st pair cm_valid", 64'(cm_valid), 64'd3);
    checkOutput("st pair cm_store", 64'(cm_store), 64'd2);
    checkOutput("st pair cm_rd", 64'(cm_rd), 64'({5'd0, 5'd1}));
    step();
    checkOutput("st s3 cm_valid", 64'(cm_valid), 64'd1);
    checkOutput("st s3 cm_store", 64'(cm_store), 64'd1);
    checkOutput("st s3 cm_tag", 64'(cm_tag[2:0]), 64'd3);
    step();
    checkOutput("st s4 cm_valid", 64'(cm_valid), 64'd1);
    checkOutput("st s4 cm_store", 64'(cm_store), 64'd1);
    checkOutput("st s4 cm_tag", 64'(cm_tag[2:0]), 64'd4);
    step();
    checkOutput("st idle cm_valid", 64'(cm_valid), 64'd0);

    // Wrap: 10 instructions, each resolved the cycle after issue
    doReset();
    begin
      logic [2:0] prevTag;
      logic [2:0] expTag;
      prevTag = 3'd0;
      for (int k = 0; k < 10; k++) begin
        idleInputs();
        issueOne(2'd0, 5'(k + 1), 32'h0);
        if (k > 0) begin
          cdb_valid = 2'b01;
          cdb_tag   = {3'd0, prevTag};
          cdb_data  = {32'h0, 32'h100 + 32'(k - 1)};
        end
        #1;
        expTag = 3'((k % 4) + 1);
        checkOutput($sformatf("wrap%0d iss_tag", k), 64'(iss_tag), 64'(expTag));
        prevTag = expTag;
        step();
        if (k >= 2) begin
          checkOutput($sformatf("wrap%0d cm_valid", k), 64'(cm_valid), 64'd1);
          checkOutput($sformatf("wrap%0d cm_tag", k), 64'(cm_tag[2:0]), 64'(((k - 2) % 4) + 1));
          checkOutput($sformatf("wrap%0d cm_data", k), 64'(cm_data[31:0]), 64'(32'h100 + 32'(k - 2)));
        end else begin
          checkOutput($sformatf("wrap%0d cm_valid", k), 64'(cm_valid), 64'd0);
        end
      end
      // Reset with issue and CDB still active
      cdb_valid = 2'b01;
      cdb_tag   = {3'd0, prevTag};
      cdb_data  = {32'h0, 32'h109};
      rst = 1'b1;
      step();
      checkOutput("rstmid cm_valid", 64'(cm_valid), 64'd0);
      checkOutput("rstmid cm_tag", 64'(cm_tag), 64'd0);
      checkOutput("rstmid cm_data", cm_data, 64'd0);
      checkOutput("rstmid iss_tag", 64'(iss_tag), 64'd1);
      rst = 1'b0;
      idleInputs();
      q_tag = {3'd2, 3'd1};
      #1;
      checkOutput("rstmid q_ready", 64'(q_ready), 64'd0);
      step();
      checkOutput("rstmid after cm_valid", 64'(cm_valid), 64'd0);
      checkOutput("rstmid after iss_ready", 64'(iss_ready), 64'd1);
      checkOutput("rstmid after iss_tag", 64'(iss_tag), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
